trig_table_loader: RTL and testbench
====================================

// Module: trig_table_loader
// PURPOSE
// - Writer side of the sin/cos lookup tables read by the vector ALU.
// - Tables are loaded at runtime from an 11-bit word stream (valid/ready), replacing fixed ROM contents.
// - Once loaded, serves ROM-compatible reads: address in, registered packed 6-lane sin/cos out, 1-cycle latency.
// PARAMETERS
// - LANES   6   vector lanes per table row
// - VAL_W   11  signed fixed-point sin/cos value width
// - DEPTH   64  table rows (angle steps)
// - ADDR_W  6   log2(DEPTH)
// PORTS
// - clk          in   1              system clock
// - rst          in   1              async reset, active-high
// - load_start   in   1              1-cycle pulse: begin (re)load
// - in_data      in   VAL_W          stream word
// - in_valid     in   1              in_data valid
// - in_ready     out  1              loader accepts word this cycle
// - rd_addr      in   ADDR_W         angle address from ALU (b[5:0])
// - sin_q        out  LANES*VAL_W    packed sin row; lane k at [(k+1)*VAL_W-1 : k*VAL_W]
// - cos_q        out  LANES*VAL_W    packed cos row, same packing
// - table_ready  out  1              both tables valid
// - busy         out  1              load in progress
// - chk_err      out  1              checksum mismatch (only with TRIG_LOAD_CHECKSUM_EN)
// BEHAVIOUR
// - One clock; rst asynchronous, active-high. Reset: FSM=IDLE, word counter=0, in_ready=0, busy=0,
//   table_ready=0, sin_q=cos_q=0, chk_err=0. Table RAM contents are not reset; table_ready gates reads.
// - FSM: IDLE -> LOAD_SIN (on load_start) -> LOAD_COS -> [LOAD_CHK] -> READY.
//   READY -> LOAD_SIN on load_start. load_start is ignored in LOAD_* states.
// - in_ready=1 and busy=1 in LOAD_SIN/LOAD_COS/LOAD_CHK; 0 elsewhere. Transfer = in_valid & in_ready.
// - Word order: sin row 0 lane 0..LANES-1, row 1, ... row DEPTH-1; then cos in the same order.
//   768 words total at defaults; counter is 10 bits; lane index = count % LANES.
// - Lane words are assembled in a row register. The row is written to RAM in the cycle its
//   lane LANES-1 word transfers. Row address = count / LANES within the current table.
// - Last sin word transfers: LOAD_SIN -> LOAD_COS next cycle, counter restarts at 0.
// - Last cos word transfers: -> READY (or LOAD_CHK with macro).
// - table_ready=1 only in READY. It drops in the cycle after load_start is accepted from READY.
// - Reads: when table_ready, sin_q/cos_q <= RAM[rd_addr] on each clk (1-cycle latency, matches ROM).
//   When not table_ready, sin_q/cos_q <= 0. The values are raw; the ALU sign-extends them.
// - Stalls: in_valid low holds all state; there is no timeout.
// - rst mid-load aborts the load: returns to IDLE, partial RAM contents are unusable, table_ready=0.
// - rd_addr wraps naturally, since all ADDR_W values are in range when DEPTH=2^ADDR_W.
// CONFIGURATION
// - TRIG_LOAD_CHECKSUM_EN defined: after the last cos word, the FSM enters LOAD_CHK and accepts one extra word.
//   - That word must equal the sum mod 2^VAL_W of all 768 data words.
//   - Match: -> READY, chk_err=0.
//   - Mismatch: -> IDLE, chk_err=1, table_ready stays 0.
//   - chk_err clears on the next accepted load_start or on rst.
// - Not defined: no LOAD_CHK state, no chk_err port, no checksum adder. LOAD_COS goes straight to READY.
// TESTING
// - Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready=0; reads give sin_q=cos_q=0.
// - Full load, in_valid always high: sin word i = i, cos word i = 0x400|i (mod 2^11) ->
//   table_ready rises after 768 transfers (+1 with checksum). Then rd_addr=3 gives, one cycle later,
//   sin_q lanes = 18..23 and cos_q lanes = 0x412..0x417.
// - Backpressure: in_valid toggled randomly at 50% -> same RAM image as the full-load test; busy high throughout.
// - Reload: in READY, pulse load_start -> table_ready=0 next cycle; reads return 0 until the new load completes.
//   load_start pulsed mid-load -> ignored, counter unchanged.
// - rst after 300 words -> IDLE, busy=0. A fresh load_start then loads correctly from word 0.
// - Checksum (TRIG_LOAD_CHECKSUM_EN): correct sum -> READY. Sum+1 -> chk_err=1, table_ready=0, FSM=IDLE.

Source files
------------

// File: rtl/trig_table_loader_if.sv
// Stream, control and table-read bundle between the sin/cos table loader and its user.
// chk_err exists only when TRIG_LOAD_CHECKSUM_EN is defined.
interface trig_table_loader_if #(
  parameter int LANES  = 6,
  parameter int VAL_W  = 11,
  parameter int ADDR_W = 6
);
  logic                   load_start;
  logic [VAL_W-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      rd_addr;
  logic [LANES*VAL_W-1:0] sin_q;
  logic [LANES*VAL_W-1:0] cos_q;
  logic                   table_ready;
  logic                   busy;
`ifdef TRIG_LOAD_CHECKSUM_EN
  logic                   chk_err;

  modport master (
    output load_start, in_data, in_valid, rd_addr,
    input  in_ready, sin_q, cos_q, table_ready, busy, chk_err
  );
  modport slave (
    input  load_start, in_data, in_valid, rd_addr,
    output in_ready, sin_q, cos_q, table_ready, busy, chk_err
  );
`else
  modport master (
    output load_start, in_data, in_valid, rd_addr,
    input  in_ready, sin_q, cos_q, table_ready, busy
  );
  modport slave (
    input  load_start, in_data, in_valid, rd_addr,
    output in_ready, sin_q, cos_q, table_ready, busy
  );
`endif
endinterface

// File: rtl/trig_table_loader.sv
// Runtime-loaded sin/cos lookup tables: 11-bit valid/ready word stream in, 1-cycle registered 6-lane reads out.
// in_ready is high for the whole load; stalls hold state. TRIG_LOAD_CHECKSUM_EN adds a trailing checksum word.
module trig_table_loader #(
  parameter int LANES  = 6,
  parameter int VAL_W  = 11,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  trig_table_loader_if.slave tl
);
  localparam int ROW_W  = LANES * VAL_W;
  localparam int WORDS  = LANES * DEPTH;
  localparam int CNT_W  = 10;
  localparam int LANE_W = $clog2(LANES);

`ifdef TRIG_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD_SIN, LOAD_COS, LOAD_CHK, READY} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_SIN, LOAD_COS, READY} state_t;
`endif

  state_t                          state, state_n;
  logic [CNT_W-1:0]                cnt;
  logic [LANE_W-1:0]               lane;
  logic [ADDR_W-1:0]               row;
  logic [LANES-2:0][VAL_W-1:0]     row_buf;
  logic [ROW_W-1:0]                wr_row;
  logic [ROW_W-1:0]                sin_ram [DEPTH];
  logic [ROW_W-1:0]                cos_ram [DEPTH];

  logic loading, xfer, data_xfer, last_word, last_lane, start_acc, wr_en;
  logic busy_c, ready_c;

  assign xfer      = tl.in_valid & tl.in_ready;
  assign loading   = (state == LOAD_SIN) || (state == LOAD_COS);
  assign data_xfer = xfer & loading;
  assign last_word = data_xfer && (cnt == CNT_W'(WORDS - 1));
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign start_acc = tl.load_start && ((state == IDLE) || (state == READY));
  assign wr_en     = data_xfer & last_lane;
  // Final lane comes straight from the bus so the row lands in RAM the cycle it completes.
  assign wr_row    = {tl.in_data, row_buf};

`ifdef TRIG_LOAD_CHECKSUM_EN
  logic [VAL_W-1:0] sum;
  logic             chk_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    ready_c = 1'b0;
    case (state)
      IDLE:     if (tl.load_start) state_n = LOAD_SIN;
      LOAD_SIN: begin
        busy_c = 1'b1;
        if (last_word) state_n = LOAD_COS;
      end
      LOAD_COS: begin
        busy_c = 1'b1;
`ifdef TRIG_LOAD_CHECKSUM_EN
        if (last_word) state_n = LOAD_CHK;
`else
        if (last_word) state_n = READY;
`endif
      end
`ifdef TRIG_LOAD_CHECKSUM_EN
      LOAD_CHK: begin
        busy_c = 1'b1;
        if (xfer) state_n = (tl.in_data == sum) ? READY : IDLE;
      end
`endif
      READY: begin
        ready_c = 1'b1;
        if (tl.load_start) state_n = LOAD_SIN;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tl.in_ready    = busy_c;
  assign tl.busy        = busy_c;
  assign tl.table_ready = ready_c;

  // cnt spans one table; lane/row track cnt % LANES and cnt / LANES incrementally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      lane    <= '0;
      row     <= '0;
      row_buf <= '0;
    end else if (start_acc) begin
      cnt  <= '0;
      lane <= '0;
      row  <= '0;
    end else if (data_xfer) begin
      if (!last_lane) row_buf[lane] <= tl.in_data;
      if (last_word) begin
        cnt  <= '0;
        lane <= '0;
        row  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (last_lane) begin
          lane <= '0;
          row  <= row + ADDR_W'(1);
        end else begin
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (state == LOAD_SIN) sin_ram[row] <= wr_row;
      else                   cos_ram[row] <= wr_row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tl.sin_q <= '0;
      tl.cos_q <= '0;
    end else if (ready_c) begin
      tl.sin_q <= sin_ram[tl.rd_addr];
      tl.cos_q <= cos_ram[tl.rd_addr];
    end else begin
      tl.sin_q <= '0;
      tl.cos_q <= '0;
    end
  end

`ifdef TRIG_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else if (start_acc) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      if (data_xfer) sum <= sum + tl.in_data;
      if (xfer && (state == LOAD_CHK) && (tl.in_data != sum)) chk_err <= 1'b1;
    end
  end

  assign tl.chk_err = chk_err;
`endif
endmodule

// File: tb/tb_trig_table_loader.sv
// Randomized bench for trig_table_loader against a word-stream/array reference model.
`timescale 1ns/1ps
module tb_trig_table_loader;
  localparam int LANES  = 6;
  localparam int VAL_W  = 11;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int ROW_W  = LANES * VAL_W;
  localparam int NDATA  = 2 * LANES * DEPTH;
`ifdef TRIG_LOAD_CHECKSUM_EN
  localparam int NSTREAM = NDATA + 1;
`else
  localparam int NSTREAM = NDATA;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trig_table_loader_if #(.LANES(LANES), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) tl ();

  trig_table_loader #(.LANES(LANES), .VAL_W(VAL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .tl  (tl)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [VAL_W-1:0] words[$];
  logic [VAL_W-1:0] sq[$];

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: word i of the stream is table i/384, row (i%384)/6, lane i%6.
  function automatic logic [ROW_W-1:0] exp_row(input int tbl, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++)
      v[k*VAL_W +: VAL_W] = words[tbl*LANES*DEPTH + r*LANES + k];
    return v;
  endfunction

  function automatic logic [VAL_W-1:0] model_sum();
    int s;
    s = 0;
    foreach (words[i]) s += int'(words[i]);
    return VAL_W'(s);
  endfunction

  task automatic make_words(input bit rnd, input int bad);
    words.delete();
    for (int i = 0; i < NDATA; i++) begin
      if (rnd)                    words.push_back(VAL_W'($urandom));
      else if (i < LANES * DEPTH) words.push_back(VAL_W'(i));
      else                        words.push_back(VAL_W'(11'h400 | (i - LANES * DEPTH)));
    end
    sq = words;
`ifdef TRIG_LOAD_CHECKSUM_EN
    sq.push_back(model_sum() + VAL_W'(bad));
`else
    if (bad != 0) sq.push_back(VAL_W'(0));
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    tl.load_start = 1'b1;
    @(negedge clk);
    tl.load_start = 1'b0;
  endtask

  task automatic stream(input int pct, input int limit, input int poke_at,
                        output int sent, output int busy_lo, output int rdy_hi);
    int cyc;
    cyc = 0; sent = 0; busy_lo = 0; rdy_hi = 0;
    while (sent < limit && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      tl.load_start = (sent == poke_at);
      tl.in_valid   = ($urandom_range(99) < pct);
      tl.in_data    = tl.in_valid ? sq[sent] : VAL_W'($urandom);
      if (!tl.busy) busy_lo++;
      if (tl.table_ready) rdy_hi++;
      if (tl.in_valid && tl.in_ready) sent++;
    end
    @(negedge clk);
    tl.in_valid   = 1'b0;
    tl.load_start = 1'b0;
  endtask

  task automatic read_row(input int a, output logic [ROW_W-1:0] s, output logic [ROW_W-1:0] c);
    @(negedge clk);
    tl.rd_addr = ADDR_W'(a);
    @(negedge clk);
    s = tl.sin_q;
    c = tl.cos_q;
  endtask

  task automatic check_image(input string tag);
    logic [ROW_W-1:0] s, c;
    for (int r = 0; r < DEPTH; r++) begin
      read_row(r, s, c);
      check({tag, "_sin"}, s, exp_row(0, r));
      check({tag, "_cos"}, c, exp_row(1, r));
    end
  endtask

  initial begin
    int sent, busy_lo, rdy_hi, a;
    logic [ROW_W-1:0] s, c, es, ec;
    tl.load_start = 1'b0; tl.in_valid = 1'b0; tl.in_data = '0; tl.rd_addr = '0;

    #12 rst = 1'b1;
    #1;
    check("rst_in_ready", tl.in_ready, 0);
    check("rst_busy", tl.busy, 0);
    check("rst_table_ready", tl.table_ready, 0);
    check("rst_sin_q", tl.sin_q, 0);
    check("rst_cos_q", tl.cos_q, 0);
`ifdef TRIG_LOAD_CHECKSUM_EN
    check("rst_chk_err", tl.chk_err, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_row(5, s, c);
    check("idle_read_sin", s, 0);
    check("idle_read_cos", c, 0);

    // Full load, no stalls, counting pattern.
    make_words(1'b0, 0);
    pulse_start();
    check("start_busy", tl.busy, 1);
    stream(100, NSTREAM, -1, sent, busy_lo, rdy_hi);
    check("full_sent", sent, NSTREAM);
    check("full_busy_lo", busy_lo, 0);
    check("full_ready_early", rdy_hi, 0);
    check("full_table_ready", tl.table_ready, 1);
    check("full_busy_done", tl.busy, 0);
    check("full_in_ready_done", tl.in_ready, 0);
`ifdef TRIG_LOAD_CHECKSUM_EN
    check("full_chk_err", tl.chk_err, 0);
`endif
    es = '0; ec = '0;
    for (int k = 0; k < LANES; k++) begin
      es[k*VAL_W +: VAL_W] = VAL_W'(18 + k);
      ec[k*VAL_W +: VAL_W] = VAL_W'(11'h412 + k);
    end
    read_row(3, s, c);
    check("row3_sin", s, es);
    check("row3_cos", c, ec);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(DEPTH - 1);
      read_row(a, s, c);
      check("rand_row_sin", s, exp_row(0, a));
      check("rand_row_cos", c, exp_row(1, a));
    end

    // Reload with random data, 50% stalls and an ignored mid-load load_start.
    tl.rd_addr = ADDR_W'(3);
    pulse_start();
    check("reload_ready_drop", tl.table_ready, 0);
    @(negedge clk);
    check("reload_read_sin0", tl.sin_q, 0);
    check("reload_read_cos0", tl.cos_q, 0);
    make_words(1'b1, 0);
    stream(50, NSTREAM, 100, sent, busy_lo, rdy_hi);
    check("bp_sent", sent, NSTREAM);
    check("bp_busy_lo", busy_lo, 0);
    check("bp_ready_early", rdy_hi, 0);
    check("bp_table_ready", tl.table_ready, 1);
    check_image("bp");

    // Reset after 300 words, then a clean load from word 0.
    make_words(1'b1, 0);
    pulse_start();
    stream(100, 300, -1, sent, busy_lo, rdy_hi);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", tl.busy, 0);
    check("midrst_in_ready", tl.in_ready, 0);
    check("midrst_table_ready", tl.table_ready, 0);
    check("midrst_sin_q", tl.sin_q, 0);
    @(negedge clk);
    rst = 1'b0;
    make_words(1'b1, 0);
    pulse_start();
    stream(50, NSTREAM, -1, sent, busy_lo, rdy_hi);
    check("after_rst_sent", sent, NSTREAM);
    check("after_rst_table_ready", tl.table_ready, 1);
    check_image("after_rst");

`ifdef TRIG_LOAD_CHECKSUM_EN
    // Checksum off by one: load must be rejected.
    make_words(1'b1, 1);
    pulse_start();
    stream(100, NSTREAM, -1, sent, busy_lo, rdy_hi);
    check("badchk_sent", sent, NSTREAM);
    check("badchk_err", tl.chk_err, 1);
    check("badchk_table_ready", tl.table_ready, 0);
    check("badchk_busy", tl.busy, 0);
    read_row(7, s, c);
    check("badchk_read_sin", s, 0);
    pulse_start();
    check("chk_err_clear", tl.chk_err, 0);
    check("chk_restart_busy", tl.busy, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
